sonar_sweep_ctrl: RTL and testbench
===================================

Name: sonar_sweep_ctrl

Overview:
- Sequences the HC-SR04 interface and servo for the sonar sweep.
- Steps the servo through N_POS positions in ping-pong order: 0..N_POS-1, then back down to 0, repeating.
- At each position it waits for mechanical settling, pulses a one-cycle measure request to the sensor interface, and waits for pronto or a timeout.
- Publishes one {position, distance} record per measurement to the downstream transmitter/display logic.

Parameters:
- N_POS, 8, number of servo positions per half-sweep (>=2).
- SETTLE_CYCLES, 25000000, clock cycles waited after a position change before measuring.
- TIMEOUT_CYCLES, 5000000, max cycles waited for pronto after the measure pulse.
- PW, $clog2(N_POS), width of position outputs.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ligar  in  1  level enable; sweep runs while high.
- pronto_i  in  1  one-cycle completion pulse from the sensor interface.
- medida_i  in  12  distance from the sensor interface, valid when pronto_i=1.
- medir_o  out  1  one-cycle measure request to the sensor interface.
- posicao  out  PW  current servo position index.
- dado_valido  out  1  one-cycle strobe: record valid.
- dado_posicao  out  PW  position of the record.
- dado_medida  out  12  distance of the record; 12'hFFF on timeout.
- erro_timeout  out  1  high with dado_valido when the record is a timeout.
- db_estado  out  4  FSM state encoding, for debug.

Behaviour:
- Reset (reset=0 at a clock edge) is synchronous and active-low. It overrides everything, including mid-measurement. Reset values:
  - state=INICIAL, posicao=0, direction=up, all counters=0.
  - medir_o, dado_valido, erro_timeout = 0.
  - dado_posicao=0, dado_medida=0.
- States (db_estado value):
  - INICIAL(0): outputs idle. If ligar=1, go to POSICIONA.
  - POSICIONA(1): settle counter counts up. When count == SETTLE_CYCLES-1, go to MEDE.
  - MEDE(2): medir_o=1 for exactly this one cycle. Timeout counter cleared. Go to AGUARDA.
  - AGUARDA(3): timeout counter increments each cycle.
    - pronto_i=1: latch medida_i, clear err, go to REGISTRA.
    - Else, when count == TIMEOUT_CYCLES-1: set dado_medida=12'hFFF, err=1, go to REGISTRA.
    - pronto_i and timeout in the same cycle: pronto wins.
  - REGISTRA(4): dado_valido=1 for one cycle. dado_posicao=posicao. erro_timeout=err. Go to PROXIMO.
  - PROXIMO(5): compute the next position.
    - Up: posicao+1; at N_POS-1 reverse to down and step to N_POS-2.
    - Down: posicao-1; at 0 reverse to up and step to 1.
    - So endpoints are measured once per turn.
    - Then: if ligar=1 go to POSICIONA, else go to INICIAL.
- ligar dropping mid-sweep:
  - The current measurement completes and its record is emitted.
  - The next position is still computed in PROXIMO, then the FSM parks in INICIAL.
  - posicao and direction are held; re-enabling resumes from there.
- pronto_i outside AGUARDA is ignored.
- dado_medida and dado_posicao hold their value between strobes.
- Minimum time between records: SETTLE_CYCLES + 4 cycles.

Optional Feature:
- Macro: SONAR_RETRY_EN.
- Defined:
  - On the first timeout at a position, return to MEDE once instead of REGISTRA. medir_o pulses again and the timeout counter is cleared.
  - A second timeout emits the 12'hFFF record.
  - The retry flag clears in PROXIMO and on reset.
  - Adds state RETENTA(6) for one cycle between AGUARDA and MEDE.
- Undefined: the first timeout goes directly to REGISTRA. No RETRY state or retry flag logic is synthesized.

Decomposition:
- Package sonar_pkg:
  - State encoding constants (INICIAL..RETENTA).
  - MEDIDA_W=12.
  - MEDIDA_TIMEOUT=12'hFFF.
- One sub-module: sonar_contador (parameterized up-counter with synchronous clear, enable, and terminal-count flag). Instantiated twice: settle and timeout.
- Position/direction logic stays inline.

Test Plan (N_POS=4, SETTLE_CYCLES=4, TIMEOUT_CYCLES=20):
1. Reset low for 2 cycles, then high with ligar=0 -> posicao=0, medir_o=0, db_estado=0, held indefinitely.
2. ligar=1. Model returns pronto_i 5 cycles after each medir_o, with medida_i=pos*100+7 -> records appear in order:
   - (0,7), (1,107), (2,207), (3,307), (2,207), (1,107), (0,7), (1,107)
   - erro_timeout=0 throughout; exactly one medir_o per record.
3. Model never answers pronto -> each record has dado_medida=12'hFFF and erro_timeout=1.
   - Without the macro: arrives 21 cycles after medir_o.
   - With SONAR_RETRY_EN: two medir_o pulses per position, record after the second timeout.
4. pronto_i asserted in the exact cycle the timeout counter hits 19, medida_i=12'd42 -> record 42, erro_timeout=0.
5. ligar dropped during AGUARDA at position 2 (going up) -> pending record (2,x) still emitted. FSM then parks in INICIAL with posicao=3. Re-raising ligar measures position 3 next.
6. reset asserted in AGUARDA -> next cycle all outputs are at reset values. A stray pronto_i one cycle later produces no dado_valido.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared constants for the sonar sweep controller: state encoding and
// measurement word format. Optional build macro: SONAR_RETRY_EN.
package sonar_pkg;

    localparam int unsigned MEDIDA_W = 12;
    localparam logic [MEDIDA_W-1:0] MEDIDA_TIMEOUT = 12'hFFF;

    // Encoding is visible on db_estado, so values are pinned explicitly.
    typedef enum logic [3:0] {
        StInicial   = 4'd0,
        StPosiciona = 4'd1,
        StMede      = 4'd2,
        StAguarda   = 4'd3,
        StRegistra  = 4'd4,
        StProximo   = 4'd5
`ifdef SONAR_RETRY_EN
        ,
        StRetenta   = 4'd6
`endif
    } estado_e;

endpackage

// File: rtl/sonar_sweep_ctrl_if.sv
// Sensor handshake and record stream of the sonar sweep controller.
// master: the controller; slave: sensor interface plus record consumer.
interface sonar_sweep_ctrl_if
    import sonar_pkg::*;
#(
    parameter int unsigned PW = 3
) ();

    logic                medir_o;
    logic                pronto_i;
    logic [MEDIDA_W-1:0] medida_i;
    logic                dado_valido;
    logic [PW-1:0]       dado_posicao;
    logic [MEDIDA_W-1:0] dado_medida;
    logic                erro_timeout;

    modport master (
        output medir_o,
        input  pronto_i,
        input  medida_i,
        output dado_valido,
        output dado_posicao,
        output dado_medida,
        output erro_timeout
    );

    modport slave (
        input  medir_o,
        output pronto_i,
        output medida_i,
        input  dado_valido,
        input  dado_posicao,
        input  dado_medida,
        input  erro_timeout
    );

endinterface

// File: rtl/sonar_contador.sv
// Up-counter with synchronous clear and enable; fim flags count == MAX-1.
// The count holds at MAX-1 rather than wrapping.
module sonar_contador #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    logic [W-1:0] count_q;

    assign fim = (count_q == W'(MAX - 1));

    // Count register: reset and clear both return to zero.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count_q <= '0;
        end else if (enable && !fim) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sonar_sweep_ctrl.sv
// Sonar sweep sequencer: steps the servo ping-pong over N_POS positions,
// settles, requests a measurement, waits for pronto or timeout, and emits
// one {position, distance} record per measurement.
// Optional build macro: SONAR_RETRY_EN (one re-measure after a first timeout).
module sonar_sweep_ctrl
    import sonar_pkg::*;
#(
    parameter int unsigned N_POS          = 8,
    parameter int unsigned SETTLE_CYCLES  = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned PW             = $clog2(N_POS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ligar,
    sonar_sweep_ctrl_if.master        bus,
    output logic [PW-1:0]             posicao,
    output logic [3:0]                db_estado
);

    estado_e             state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                up_q, up_d;
    logic [MEDIDA_W-1:0] medida_q, medida_d;
    logic [PW-1:0]       dado_pos_q, dado_pos_d;
    logic                err_q, err_d;
    logic                settle_fim, timeout_fim;
`ifdef SONAR_RETRY_EN
    logic                retry_q, retry_d;
`endif

    sonar_contador #(
        .MAX (SETTLE_CYCLES)
    ) u_settle (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != StPosiciona),
        .enable (state_q == StPosiciona),
        .fim    (settle_fim)
    );

    // Cleared in every state but AGUARDA, so MEDE always restarts it at zero.
    sonar_contador #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != StAguarda),
        .enable (state_q == StAguarda),
        .fim    (timeout_fim)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StInicial;
            pos_q      <= '0;
            up_q       <= 1'b1;
            medida_q   <= '0;
            dado_pos_q <= '0;
            err_q      <= 1'b0;
`ifdef SONAR_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            up_q       <= up_d;
            medida_q   <= medida_d;
            dado_pos_q <= dado_pos_d;
            err_q      <= err_d;
`ifdef SONAR_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Next-state, record capture and position stepping.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        up_d       = up_q;
        medida_d   = medida_q;
        dado_pos_d = dado_pos_q;
        err_d      = err_q;
`ifdef SONAR_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            StInicial: begin
                if (ligar) state_d = StPosiciona;
            end
            StPosiciona: begin
                if (settle_fim) state_d = StMede;
            end
            StMede: begin
                state_d = StAguarda;
            end
            StAguarda: begin
                // pronto has priority over a timeout in the same cycle.
                if (bus.pronto_i) begin
                    medida_d   = bus.medida_i;
                    err_d      = 1'b0;
                    dado_pos_d = pos_q;
                    state_d    = StRegistra;
                end else if (timeout_fim) begin
`ifdef SONAR_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = StRetenta;
                    end else begin
                        medida_d   = MEDIDA_TIMEOUT;
                        err_d      = 1'b1;
                        dado_pos_d = pos_q;
                        state_d    = StRegistra;
                    end
`else
                    medida_d   = MEDIDA_TIMEOUT;
                    err_d      = 1'b1;
                    dado_pos_d = pos_q;
                    state_d    = StRegistra;
`endif
                end
            end
            StRegistra: begin
                state_d = StProximo;
            end
            StProximo: begin
                // Endpoints reverse direction and step inward, so each is
                // measured once per turn.
                if (up_q) begin
                    if (pos_q == PW'(N_POS - 1)) begin
                        up_d  = 1'b0;
                        pos_d = PW'(N_POS - 2);
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        up_d  = 1'b1;
                        pos_d = PW'(1);
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
`ifdef SONAR_RETRY_EN
                retry_d = 1'b0;
`endif
                state_d = ligar ? StPosiciona : StInicial;
            end
`ifdef SONAR_RETRY_EN
            StRetenta: begin
                state_d = StMede;
            end
`endif
            default: begin
                state_d = StInicial;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.medir_o      = (state_q == StMede);
        bus.dado_valido  = (state_q == StRegistra);
        bus.erro_timeout = (state_q == StRegistra) && err_q;
        bus.dado_posicao = dado_pos_q;
        bus.dado_medida  = medida_q;
        posicao          = pos_q;
        db_estado        = state_q;
    end

endmodule

// File: tb/tb_sonar_sweep_ctrl.sv
// Self-checking bench for sonar_sweep_ctrl (N_POS=4, SETTLE=4, TIMEOUT=20).
// Honours SONAR_RETRY_EN for timeout expectations.
module tb_sonar_sweep_ctrl;

    localparam int unsigned N_POS   = 4;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 20;
`ifdef SONAR_RETRY_EN
    localparam int NM_TO = 2;
`else
    localparam int NM_TO = 1;
`endif

    typedef struct {
        logic [1:0]  pos;
        logic [11:0] med;
        logic        err;
        int          n_medir;
        int          lat;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic [1:0] posicao;
    logic [3:0] db_estado;

    int   n_cmp = 0;
    int   n_mis = 0;
    rec_t q[$];
    int   mode = 1;        // 0: answer after 5 cycles, 1: never, 2: answer at count 19
    int   stray_req = 0;
    int   stray_done = 0;
    int   medir_cnt = 0;
    int   lat = 0;

    sonar_sweep_ctrl_if #(.PW(2)) bus ();

    sonar_sweep_ctrl #(
        .N_POS          (N_POS),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ligar     (ligar),
        .bus       (bus),
        .posicao   (posicao),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] p, input logic [11:0] m, input logic e,
                        input int nm, input int l);
        rec_t r;
        r.pos = p; r.med = m; r.err = e; r.n_medir = nm; r.lat = l;
        q.push_back(r);
    endtask

    task automatic wait_size(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && q.size() > n; i++) begin
            @(negedge clock); #1;
        end
        chk(tag, q.size(), n);
        if (q.size() > n) q.delete();
    endtask

    task automatic wait_medir(input int budget, input string tag);
        for (int i = 0; i < budget && !bus.medir_o; i++) begin
            @(negedge clock); #1;
        end
        chk(tag, bus.medir_o, 1'b1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clock); #1; end
    endtask

    // Sensor model: owns pronto_i/medida_i.
    initial begin : responder
        int          cnt;
        logic        armed;
        logic [11:0] val;
        cnt = 0; armed = 1'b0; val = '0;
        bus.pronto_i = 1'b0;
        bus.medida_i = '0;
        forever begin
            @(negedge clock);
            bus.pronto_i = 1'b0;
            if (stray_req != stray_done) begin
                bus.pronto_i = 1'b1;
                bus.medida_i = 12'd99;
                stray_done++;
            end else if (bus.medir_o) begin
                armed = (mode != 1);
                cnt   = (mode == 2) ? 20 : 5;
                val   = (mode == 2) ? 12'd42 : 12'(int'(posicao) * 100 + 7);
            end else if (armed) begin
                cnt--;
                if (cnt == 0) begin
                    bus.pronto_i = 1'b1;
                    bus.medida_i = val;
                    armed = 1'b0;
                end
            end
        end
    end

    // Record monitor: pops the scoreboard on each dado_valido.
    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clock);
            if (bus.medir_o) begin
                medir_cnt++;
                lat = 0;
            end else begin
                lat++;
            end
            if (bus.dado_valido) begin
                if (q.size() == 0) begin
                    chk("unexpected_record", bus.dado_valido, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("rec_pos", bus.dado_posicao, e.pos);
                    chk("rec_medida", bus.dado_medida, e.med);
                    chk("rec_err", bus.erro_timeout, e.err);
                    chk("rec_n_medir", medir_cnt, e.n_medir);
                    if (e.lat != 0) chk("rec_latency", lat, e.lat);
                end
                medir_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b0;
        ligar = 1'b0;
        mode  = 1;
        cycles(2);
        chk("rst_dado_medida", bus.dado_medida, 12'd0);
        chk("rst_dado_posicao", bus.dado_posicao, 2'd0);
        chk("rst_erro", bus.erro_timeout, 1'b0);
        reset = 1'b1;

        // 1: idle with ligar low
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            chk("idle_posicao", posicao, 2'd0);
            chk("idle_medir", bus.medir_o, 1'b0);
            chk("idle_estado", db_estado, 4'd0);
        end

        // 2: normal ping-pong sweep
        mode = 0;
        push(0, 12'd7, 0, 1, 6);
        push(1, 12'd107, 0, 1, 6);
        push(2, 12'd207, 0, 1, 6);
        push(3, 12'd307, 0, 1, 6);
        push(2, 12'd207, 0, 1, 6);
        push(1, 12'd107, 0, 1, 6);
        push(0, 12'd7, 0, 1, 6);
        push(1, 12'd107, 0, 1, 6);
        ligar = 1'b1;
        wait_size(0, 1000, "sweep_done");
        ligar = 1'b0;
        cycles(3);
        chk("park1_estado", db_estado, 4'd0);
        chk("park1_posicao", posicao, 2'd2);

        // 3: sensor never answers
        mode = 1;
        push(2, 12'hFFF, 1, NM_TO, 21);
        push(3, 12'hFFF, 1, NM_TO, 21);
        ligar = 1'b1;
        wait_size(0, 400, "timeout_done");
        ligar = 1'b0;
        cycles(3);
        chk("park2_posicao", posicao, 2'd2);

        // 4: pronto in the same cycle as the timeout terminal count
        mode = 2;
        push(2, 12'd42, 0, 1, 21);
        ligar = 1'b1;
        wait_size(0, 200, "race_done");
        ligar = 1'b0;
        cycles(3);
        chk("park3_posicao", posicao, 2'd1);

        // 5: ligar dropped in AGUARDA at position 2 going up
        mode = 0;
        push(1, 12'd107, 0, 1, 6);
        push(0, 12'd7, 0, 1, 6);
        push(1, 12'd107, 0, 1, 6);
        push(2, 12'd207, 0, 1, 6);
        ligar = 1'b1;
        wait_size(1, 300, "pre_drop");
        wait_medir(50, "medir_pos2");
        cycles(2);
        chk("drop_in_aguarda", db_estado, 4'd3);
        ligar = 1'b0;
        wait_size(0, 50, "drop_record");
        cycles(4);
        chk("drop_estado", db_estado, 4'd0);
        chk("drop_posicao", posicao, 2'd3);
        cycles(10);
        chk("drop_hold_posicao", posicao, 2'd3);
        push(3, 12'd307, 0, 1, 6);
        ligar = 1'b1;
        wait_size(0, 100, "resume_record");

        // 6: reset in AGUARDA, then a stray pronto
        mode = 1;
        wait_medir(50, "medir_pre_reset");
        cycles(3);
        chk("pre_reset_estado", db_estado, 4'd3);
        reset = 1'b0;
        ligar = 1'b0;
        cycles(1);
        chk("mid_rst_medir", bus.medir_o, 1'b0);
        chk("mid_rst_valido", bus.dado_valido, 1'b0);
        chk("mid_rst_erro", bus.erro_timeout, 1'b0);
        chk("mid_rst_dado_pos", bus.dado_posicao, 2'd0);
        chk("mid_rst_dado_med", bus.dado_medida, 12'd0);
        chk("mid_rst_posicao", posicao, 2'd0);
        chk("mid_rst_estado", db_estado, 4'd0);
        reset = 1'b1;
        stray_req++;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            chk("stray_valido", bus.dado_valido, 1'b0);
            chk("stray_estado", db_estado, 4'd0);
        end
        chk("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
